// File: rtl/mem_responder_pkg.sv
// Shared bus types for the core/memory request-response path.
// Also used by the core's bus-side FSM, so keep the state encoding stable.
package mem_responder_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned depth);
    return {{(32-ADDR_W){1'b0}}, addr} < depth;
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// DEPTH x DATA_W single-port store: synchronous write, registered read, no reset.
// Read data appears the cycle after an enabled read and holds until the next one.
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem_q[idx];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (en && we) mem_q[idx] <= wdata;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// One-outstanding valid/ready memory responder; access WAIT_CYCLES+1 edges after accept.
// Response is held until rsp_ready; no new request is taken while one is in flight.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              rd_sel_q, rd_sel_d;
  logic              err_q, err_d;
  logic              acc_en;
  logic              in_range;
  logic [DATA_W-1:0] arr_rdata;

  assign in_range = addr_in_range(addr_q, DEPTH);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_sel_d = rd_sel_q;
    err_d    = err_q;
    acc_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          acc_en   = 1'b1;
          err_d    = !in_range;
          rd_sel_d = in_range && !we_q;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          err_d    = 1'b0;
          rd_sel_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      rd_sel_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      rd_sel_q <= rd_sel_d;
      err_q    <= err_d;
    end
  end

  // Gate with rst so a store that reaches its access edge during reset is dropped.
  mem_responder_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .en    (acc_en && in_range && !rst),
    .we    (we_q),
    .idx   (addr_q[IDX_W-1:0]),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  assign req_ready = ready_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = err_q;
  assign rsp_rdata = rd_sel_q ? arr_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with WAIT_CYCLES = 0, 1, 3.
// Vector table drives instance 1; hand sequences cover stalls, reset and throughput.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req_valid, req_we, rsp_ready;
  logic [2:0]  req_ready, rsp_valid, rsp_err;
  logic [11:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [31:0] rsp_rdata [3];

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.DEPTH(32), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]));

  mem_responder #(.DEPTH(32), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]));

  mem_responder #(.DEPTH(32), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2]));

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Waits for req_ready, issues one request, then consumes its response.
  task automatic do_req(input int i, input logic we, input logic [11:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
    int t;
    rd = '0;
    er = 1'b0;
    lat = -1;
    req_we[i] = we;
    req_addr[i] = addr;
    req_wdata[i] = wd;
    req_valid[i] = 1'b1;
    t = 0;
    while (!req_ready[i] && t < 50) begin step(); t++; end
    if (!req_ready[i]) begin
      fail_timeout("req_ready");
      req_valid[i] = 1'b0;
      return;
    end
    step();
    req_valid[i] = 1'b0;
    req_addr[i] = 12'hABC;
    req_wdata[i] = 32'hFFFF_FFFF;
    lat = 0;
    while (!rsp_valid[i] && lat < 50) begin step(); lat++; end
    if (!rsp_valid[i]) begin
      fail_timeout("rsp_valid");
      return;
    end
    rd = rsp_rdata[i];
    er = rsp_err[i];
    rsp_ready[i] = 1'b1;
    step();
    rsp_ready[i] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          t;
    logic        seen;
    int          acc [4];

    vecs[0]  = '{1'b1, 12'd2,     32'h0000_0030, 32'h0,          1'b0};
    vecs[1]  = '{1'b0, 12'd2,     32'h0,         32'h0000_0030,  1'b0};
    vecs[2]  = '{1'b1, 12'd8,     32'h1111_1111, 32'h0,          1'b0};
    vecs[3]  = '{1'b1, 12'd31,    32'hA5A5_A5A5, 32'h0,          1'b0};
    vecs[4]  = '{1'b0, 12'd31,    32'h0,         32'hA5A5_A5A5,  1'b0};
    vecs[5]  = '{1'b0, 12'd40,    32'h0,         32'h0,          1'b1};
    vecs[6]  = '{1'b1, 12'd40,    32'hFFFF_FFFF, 32'h0,          1'b1};
    vecs[7]  = '{1'b0, 12'd8,     32'h0,         32'h1111_1111,  1'b0};
    vecs[8]  = '{1'b0, 12'd32,    32'h0,         32'h0,          1'b1};
    vecs[9]  = '{1'b0, 12'hFFF,   32'h0,         32'h0,          1'b1};
    vecs[10] = '{1'b1, 12'd0,     32'h0000_0008, 32'h0,          1'b0};
    vecs[11] = '{1'b0, 12'd0,     32'h0,         32'h0000_0008,  1'b0};

    rst = 1'b1;
    req_valid = '0;
    req_we = '0;
    rsp_ready = '0;
    for (int i = 0; i < 3; i++) begin
      req_addr[i] = '0;
      req_wdata[i] = '0;
    end

    // Reset and idle state
    repeat (3) step();
    check("ready_in_reset", {29'd0, req_ready}, 32'd0);
    check("rsp_valid_in_reset", {29'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    step();
    check("ready_after_reset", {29'd0, req_ready}, 32'd7);
    check("rsp_valid_after_reset", {29'd0, rsp_valid}, 32'd0);
    check("rsp_err_after_reset", {29'd0, rsp_err}, 32'd0);
    for (int i = 0; i < 3; i++) check("rdata_after_reset", rsp_rdata[i], 32'd0);

    // Vector table on WAIT_CYCLES=1: latency is 2 edges after acceptance
    for (int v = 0; v < 12; v++) begin
      do_req(1, vecs[v].we, vecs[v].addr, vecs[v].wdata, rd, er, lat);
      check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
      check($sformatf("vec%0d_err", v), {31'd0, er}, {31'd0, vecs[v].exp_err});
      check($sformatf("vec%0d_lat", v), lat, 32'd2);
    end

    // Stalled response on WAIT_CYCLES=0
    do_req(0, 1'b1, 12'd0, 32'h8, rd, er, lat);
    check("w0_store_lat", lat, 32'd1);
    req_we[0] = 1'b0;
    req_addr[0] = 12'd0;
    req_valid[0] = 1'b1;
    t = 0;
    while (!req_ready[0] && t < 50) begin step(); t++; end
    step();
    req_valid[0] = 1'b0;
    t = 0;
    while (!rsp_valid[0] && t < 50) begin step(); t++; end
    if (!rsp_valid[0]) fail_timeout("w0_read_rsp");
    req_we[0] = 1'b1;
    req_wdata[0] = 32'h0000_0BAD;
    req_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall%0d_valid", c), {31'd0, rsp_valid[0]}, 32'd1);
      check($sformatf("stall%0d_rdata", c), rsp_rdata[0], 32'h8);
      check($sformatf("stall%0d_ready", c), {31'd0, req_ready[0]}, 32'd0);
      step();
    end
    rsp_ready[0] = 1'b1;
    step();
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b0;
    check("release_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("release_rdata", rsp_rdata[0], 32'd0);
    check("release_ready", {31'd0, req_ready[0]}, 32'd1);
    do_req(0, 1'b0, 12'd0, 32'h0, rd, er, lat);
    check("ignored_store", rd, 32'h8);

    // Reset during WAIT drops the store (WAIT_CYCLES=3)
    do_req(2, 1'b1, 12'd5, 32'h0, rd, er, lat);
    check("w3_store_lat", lat, 32'd4);
    req_we[2] = 1'b1;
    req_addr[2] = 12'd5;
    req_wdata[2] = 32'hDEAD_BEEF;
    req_valid[2] = 1'b1;
    t = 0;
    while (!req_ready[2] && t < 50) begin step(); t++; end
    step();
    req_valid[2] = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      seen = seen | rsp_valid[2];
      step();
    end
    check("no_rsp_after_rst", {31'd0, seen}, 32'd0);
    do_req(2, 1'b0, 12'd5, 32'h0, rd, er, lat);
    check("dropped_store", rd, 32'h0);

    // Reset during RESP keeps the already-committed store
    req_we[2] = 1'b1;
    req_addr[2] = 12'd6;
    req_wdata[2] = 32'h0000_0077;
    req_valid[2] = 1'b1;
    t = 0;
    while (!req_ready[2] && t < 50) begin step(); t++; end
    step();
    req_valid[2] = 1'b0;
    t = 0;
    while (!rsp_valid[2] && t < 50) begin step(); t++; end
    if (!rsp_valid[2]) fail_timeout("w3_store_rsp");
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rsp_cleared_by_rst", {31'd0, rsp_valid[2]}, 32'd0);
    step();
    do_req(2, 1'b0, 12'd6, 32'h0, rd, er, lat);
    check("kept_store", rd, 32'h77);

    // Back-to-back fetches with rsp_ready tied high (WAIT_CYCLES=1)
    for (int j = 0; j < 4; j++) do_req(1, 1'b1, 12'(3 + j), 32'h100 + j, rd, er, lat);
    rsp_ready[1] = 1'b1;
    req_we[1] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      req_addr[1] = 12'(3 + j);
      req_valid[1] = 1'b1;
      t = 0;
      while (!req_ready[1] && t < 50) begin step(); t++; end
      step();
      acc[j] = cyc;
      req_valid[1] = 1'b0;
      t = 0;
      while (!rsp_valid[1] && t < 50) begin step(); t++; end
      if (!rsp_valid[1]) fail_timeout("b2b_rsp");
      check($sformatf("b2b%0d_rdata", j), rsp_rdata[1], 32'h100 + j);
      if (j > 0) check($sformatf("b2b%0d_gap", j), acc[j] - acc[j-1], 32'd4);
    end
    rsp_ready[1] = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
